// File: rtl/trig_lookup_arbiter.sv
// Round-robin arbiter sharing one sin/cos ROM pair between player (0) and opponent (1).
// Optional build macro TRIG_ARB_RANGE_CHECK_EN: out-of-range directions return 0 and set sticky dir_err.
module trig_lookup_arbiter #(
  parameter int ROM_LATENCY = 2,
  parameter int DIR_MAX     = 360
) (
  input  logic        clk,
  input  logic        btnc,
  input  logic        en,
  input  logic [1:0]  req,
  input  logic [8:0]  p_dir,
  input  logic [8:0]  o_dir,
  output logic [1:0]  gnt,
  output logic [8:0]  rom_addr,
  input  logic [10:0] rom_cos,
  input  logic [10:0] rom_sin,
  output logic        p_valid,
  output logic [10:0] p_cos,
  output logic [10:0] p_sin,
  output logic        o_valid,
  output logic [10:0] o_cos,
  output logic [10:0] o_sin,
  output logic        busy
`ifdef TRIG_ARB_RANGE_CHECK_EN
  ,
  output logic [1:0]  dir_err
`endif
);

  // One stage per cycle from address issue until ROM data is valid.
  localparam int DEPTH = ROM_LATENCY + 1;

  logic [DEPTH-1:0] pipe_valid;
  logic [DEPTH-1:0] pipe_tag;
  logic [DEPTH-1:0] pipe_zero;
  logic             last_grant;
  logic [8:0]       sel_dir;
  logic [8:0]       issue_addr;
  logic             issue_zero;
  logic             out_of_range;

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (en && !btnc) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end

    sel_dir      = gnt[1] ? o_dir : p_dir;
    out_of_range = (sel_dir >= 9'(DIR_MAX));
`ifdef TRIG_ARB_RANGE_CHECK_EN
    issue_addr   = out_of_range ? 9'd0 : sel_dir;
    issue_zero   = out_of_range;
`else
    issue_addr   = out_of_range ? sel_dir - 9'(DIR_MAX) : sel_dir;
    issue_zero   = 1'b0;
`endif
  end

  assign busy = |pipe_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (btnc) begin
      rom_addr   <= '0;
      pipe_valid <= '0;
      pipe_tag   <= '0;
      pipe_zero  <= '0;
      last_grant <= 1'b1;
      p_valid    <= 1'b0;
      p_cos      <= '0;
      p_sin      <= '0;
      o_valid    <= 1'b0;
      o_cos      <= '0;
      o_sin      <= '0;
`ifdef TRIG_ARB_RANGE_CHECK_EN
      dir_err    <= '0;
`endif
    end else begin
      p_valid    <= 1'b0;
      o_valid    <= 1'b0;
      pipe_valid <= {pipe_valid[DEPTH-2:0], |gnt};
      pipe_tag   <= {pipe_tag[DEPTH-2:0], gnt[1]};
      pipe_zero  <= {pipe_zero[DEPTH-2:0], issue_zero};

      if (|gnt) begin
        rom_addr   <= issue_addr;
        last_grant <= gnt[1];
`ifdef TRIG_ARB_RANGE_CHECK_EN
        if (out_of_range) dir_err[gnt[1]] <= 1'b1;
`endif
      end

      // Oldest stage lines up with ROM douta; route it to the requester that issued it.
      if (pipe_valid[DEPTH-1]) begin
        if (pipe_tag[DEPTH-1]) begin
          o_valid <= 1'b1;
          o_cos   <= pipe_zero[DEPTH-1] ? 11'd0 : rom_cos;
          o_sin   <= pipe_zero[DEPTH-1] ? 11'd0 : rom_sin;
        end else begin
          p_valid <= 1'b1;
          p_cos   <= pipe_zero[DEPTH-1] ? 11'd0 : rom_cos;
          p_sin   <= pipe_zero[DEPTH-1] ? 11'd0 : rom_sin;
        end
      end
    end
  end

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Bench for trig_lookup_arbiter: vector table for grants plus a scoreboard for returned lookups.
module tb_trig_lookup_arbiter;

  logic        clk = 1'b0;
  logic        btnc = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [8:0]  p_dir = '0;
  logic [8:0]  o_dir = '0;
  logic [1:0]  gnt;
  logic [8:0]  rom_addr;
  logic [10:0] rom_cos, rom_sin;
  logic        p_valid, o_valid, busy;
  logic [10:0] p_cos, p_sin, o_cos, o_sin;
`ifdef TRIG_ARB_RANGE_CHECK_EN
  logic [1:0]  dir_err;
`endif

  trig_lookup_arbiter dut (
    .clk(clk), .btnc(btnc), .en(en), .req(req), .p_dir(p_dir), .o_dir(o_dir),
    .gnt(gnt), .rom_addr(rom_addr), .rom_cos(rom_cos), .rom_sin(rom_sin),
    .p_valid(p_valid), .p_cos(p_cos), .p_sin(p_sin),
    .o_valid(o_valid), .o_cos(o_cos), .o_sin(o_sin), .busy(busy)
`ifdef TRIG_ARB_RANGE_CHECK_EN
    , .dir_err(dir_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ROM contents model; entry 90 is the test-plan anchor (cos=0, sin=1024).
  function automatic logic [10:0] cos_f(input logic [8:0] a);
    return (a == 9'd90) ? 11'd0 : 11'((int'(a) * 5 + 1) % 2048);
  endfunction
  function automatic logic [10:0] sin_f(input logic [8:0] a);
    return (a == 9'd90) ? 11'd1024 : 11'((int'(a) * 3 + 2) % 2048);
  endfunction

  // Two-cycle registered ROM read.
  logic [10:0] r1c = '0, r1s = '0, r2c = '0, r2s = '0;
  always @(posedge clk) begin
    r1c <= cos_f(rom_addr);
    r1s <= sin_f(rom_addr);
    r2c <= r1c;
    r2s <= r1s;
  end
  assign rom_cos = r2c;
  assign rom_sin = r2s;

  typedef struct {
    int          due;
    logic        tag;
    logic [10:0] c;
    logic [10:0] s;
  } exp_t;
  exp_t sb[$];

  logic [10:0] m_p_cos = '0, m_p_sin = '0, m_o_cos = '0, m_o_sin = '0;
  logic [8:0]  m_addr = '0;
  logic [1:0]  m_err = '0;

  // Scoreboard side: busy window and in-order returns with exact latency.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      exp_t e;
      exp_busy = 1'b0;
      foreach (sb[i]) if (cyc >= sb[i].due - 3 && cyc <= sb[i].due - 1) exp_busy = 1'b1;
      check("busy", busy, exp_busy);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++; n_bad++;
        $display("FAIL missed_valid: no valid seen, expected at cycle %0d", sb[0].due);
        void'(sb.pop_front());
      end
      if (p_valid || o_valid) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_valid: p_valid=%0d o_valid=%0d, expected none (cycle %0d)",
                   p_valid, o_valid, cyc);
        end else begin
          e = sb.pop_front();
          check("valid_cycle", cyc, e.due);
          check("valid_tag", {p_valid, o_valid}, e.tag ? 2'b01 : 2'b10);
          if (e.tag) begin m_o_cos = e.c; m_o_sin = e.s; end
          else       begin m_p_cos = e.c; m_p_sin = e.s; end
          check("p_cos", p_cos, m_p_cos);
          check("p_sin", p_sin, m_p_sin);
          check("o_cos", o_cos, m_o_cos);
          check("o_sin", o_sin, m_o_sin);
        end
      end
    end
  end

  typedef struct {
    logic       en;
    logic [1:0] req;
    logic [8:0] p;
    logic [8:0] o;
    logic [1:0] gnt;
  } vec_t;
  vec_t tbl[17];

  task automatic do_reset();
    btnc = 1'b1; en = 1'b0; req = 2'b00;
    @(posedge clk); #1;
    btnc = 1'b0;
    sb.delete();
    m_p_cos = '0; m_p_sin = '0; m_o_cos = '0; m_o_sin = '0;
    m_addr = '0; m_err = '0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'b11,  9'd90,  9'd30, 2'b00};
    tbl[1]  = '{1'b1, 2'b11,  9'd90,  9'd30, 2'b01};
    tbl[2]  = '{1'b1, 2'b11,  9'd10,  9'd30, 2'b10};
    tbl[3]  = '{1'b1, 2'b11,  9'd11,  9'd31, 2'b01};
    tbl[4]  = '{1'b1, 2'b11,  9'd12,  9'd32, 2'b10};
    tbl[5]  = '{1'b1, 2'b00,  9'd13,  9'd33, 2'b00};
    tbl[6]  = '{1'b1, 2'b01, 9'd450,  9'd33, 2'b01};
    tbl[7]  = '{1'b1, 2'b10,  9'd14, 9'd400, 2'b10};
    tbl[8]  = '{1'b1, 2'b01, 9'd359,  9'd34, 2'b01};
    tbl[9]  = '{1'b1, 2'b11,   9'd0, 9'd511, 2'b10};
    tbl[10] = '{1'b1, 2'b11, 9'd360,   9'd1, 2'b01};
    tbl[11] = '{1'b1, 2'b10,  9'd15, 9'd359, 2'b10};
    tbl[12] = '{1'b0, 2'b11,  9'd16,  9'd35, 2'b00};
    tbl[13] = '{1'b1, 2'b00,  9'd16,  9'd35, 2'b00};
    tbl[14] = '{1'b1, 2'b00,  9'd16,  9'd35, 2'b00};
    tbl[15] = '{1'b1, 2'b00,  9'd16,  9'd35, 2'b00};
    tbl[16] = '{1'b1, 2'b00,  9'd16,  9'd35, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    check("rst_gnt", gnt, 2'b00);
    check("rst_rom_addr", rom_addr, 9'd0);
    check("rst_valids", {p_valid, o_valid}, 2'b00);
    check("rst_outputs", {p_cos, p_sin, o_cos, o_sin} == '0, 1'b1);
    check("rst_busy", busy, 1'b0);
    mon_en = 1'b1;

    foreach (tbl[k]) begin
      logic [8:0] d, a;
      logic       oor;
      exp_t       e;
      en = tbl[k].en; req = tbl[k].req; p_dir = tbl[k].p; o_dir = tbl[k].o;
      @(negedge clk);
      check($sformatf("gnt_row%0d", k), gnt, tbl[k].gnt);
      if (tbl[k].gnt != 2'b00) begin
        d   = tbl[k].gnt[1] ? tbl[k].o : tbl[k].p;
        oor = (d >= 9'd360);
        a   = oor ? d - 9'd360 : d;
        e.due = cyc + 4;
        e.tag = tbl[k].gnt[1];
`ifdef TRIG_ARB_RANGE_CHECK_EN
        e.c = oor ? 11'd0 : cos_f(d);
        e.s = oor ? 11'd0 : sin_f(d);
        if (oor) m_err[tbl[k].gnt[1]] = 1'b1;
        else     m_addr = d;
`else
        e.c = cos_f(a);
        e.s = sin_f(a);
        m_addr = a;
`endif
        sb.push_back(e);
      end
      @(posedge clk); #1;
`ifdef TRIG_ARB_RANGE_CHECK_EN
      if (!(tbl[k].gnt != 2'b00 && ((tbl[k].gnt[1] ? tbl[k].o : tbl[k].p) >= 9'd360)))
        check($sformatf("rom_addr_row%0d", k), rom_addr, m_addr);
`else
      check($sformatf("rom_addr_row%0d", k), rom_addr, m_addr);
`endif
    end

    req = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
`ifdef TRIG_ARB_RANGE_CHECK_EN
    check("dir_err_sticky", dir_err, m_err);
`endif

    // Reset mid-flight: grant in T, reset in T+2, nothing comes back.
    mon_en = 1'b0;
    do_reset();
`ifdef TRIG_ARB_RANGE_CHECK_EN
    check("dir_err_cleared", dir_err, 2'b00);
`endif
    en = 1'b1; req = 2'b01; p_dir = 9'd45;
    @(negedge clk);
    check("mid_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    check("mid_busy_inflight", busy, 1'b1);
    @(posedge clk); #1;
    btnc = 1'b1;
    @(posedge clk); #1;
    btnc = 1'b0;
    check("mid_busy_after_rst", busy, 1'b0);
    check("mid_rom_addr", rom_addr, 9'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_valid", {p_valid, o_valid}, 2'b00);
      check("mid_p_out", {p_cos, p_sin}, 22'd0);
      check("mid_busy", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
